// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared constants and types for the iterative multiply/divide
//               sequencer: ALUFun codes, operation encodings, FSM states and
//               the iteration count.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

  // One shift/accumulate step per operand bit.
  localparam int ITERS = 32;

  // ALUFun codes understood by the shared ALU.
  localparam logic [5:0] ALU_ADD = 6'b000000;
  localparam logic [5:0] ALU_SUB = 6'b000001;
  localparam logic [5:0] ALU_LTU = 6'b110101;

  // Operation encodings: bit 1 selects divide, bit 0 selects unsigned.
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ITER_A = 2'b01,
    ST_ITER_B = 2'b10,
    ST_FIXUP  = 2'b11
  } state_t;

endpackage : muldiv_pkg
`default_nettype wire

// File: rtl/muldiv_signfix.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_signfix
// Description : Combinational conditional negation. In wide mode the 64-bit
//               input is negated as one value under neg_hi; otherwise each
//               32-bit half is negated independently (neg_hi / neg_lo).
//               Used for operand magnitudes at entry and for the result
//               sign fixup.
// Ports       : x      - 64-bit input {hi, lo}
//               wide   - 1: treat x as one 64-bit value
//               neg_hi - negate upper half (or whole value in wide mode)
//               neg_lo - negate lower half (ignored in wide mode)
//               y      - result
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_signfix (
  input  logic [63:0] x,
  input  logic        wide,
  input  logic        neg_hi,
  input  logic        neg_lo,
  output logic [63:0] y
);

  always_comb begin
    y = x;
    if (wide) begin
      if (neg_hi) y = 64'd0 - x;
    end else begin
      if (neg_hi) y[63:32] = 32'd0 - x[63:32];
      if (neg_lo) y[31:0]  = 32'd0 - x[31:0];
    end
  end

endmodule : muldiv_signfix
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_seq
// Description : Iterative MULT/MULTU/DIV/DIVU sequencer. Borrows the shared
//               32-bit ALU for two cycles per bit (32 bits), owns HI/LO.
// Ports       : clk, reset (sync, active-high)
//               start/op/opa/opb - request, accepted when not busy
//               busy/done        - status; done pulses when hi/lo update
//               hi/lo            - result registers
//               alu_own/alu_a/alu_b/alu_fun/alu_sign - shared ALU request
//               alu_z            - shared ALU result (same cycle)
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_seq
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        alu_own,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [5:0]  alu_fun,
  output logic        alu_sign,
  input  logic [31:0] alu_z
);

  localparam logic [5:0] LAST = 6'(ITERS - 1);

  state_t      state;
  logic        div_op;     // latched op[1]
  logic        neg_q;      // negate quotient / product
  logic        neg_r;      // negate remainder
  logic [31:0] acc;        // product high half, or partial remainder
  logic [31:0] wlo;        // multiplier/product low half, or dividend/quotient
  logic [31:0] breg;       // multiplicand or divisor magnitude
  logic [31:0] sum;        // ITER_A result carried into ITER_B
  logic [31:0] addend;     // multiply addend, needed for carry detection
  logic        ge;         // divide: shifted remainder >= divisor
  logic [5:0]  count;

  logic [31:0] rs;
  logic        signed_in;
  logic [63:0] abs_ops;
  logic [63:0] fix_res;
  logic        fix_neg_hi;

  // Shifted partial remainder; bit 31 of acc drops out but is kept via ge.
  assign rs        = {acc[30:0], wlo[31]};
  assign signed_in = ~op[0];
  assign fix_neg_hi = div_op ? neg_r : neg_q;

  muldiv_signfix u_abs (
    .x      ({opa, opb}),
    .wide   (1'b0),
    .neg_hi (signed_in & opa[31]),
    .neg_lo (signed_in & opb[31]),
    .y      (abs_ops)
  );

  muldiv_signfix u_fix (
    .x      ({acc, wlo}),
    .wide   (~div_op),
    .neg_hi (fix_neg_hi),
    .neg_lo (neg_q),
    .y      (fix_res)
  );

  assign alu_own  = busy;
  assign alu_sign = 1'b0;

  // ALU request is a pure function of registered state.
  always_comb begin
    alu_a   = 32'd0;
    alu_b   = 32'd0;
    alu_fun = ALU_ADD;
    case (state)
      ST_ITER_A: begin
        if (div_op) begin
          alu_a   = rs;
          alu_b   = breg;
          alu_fun = ALU_LTU;
        end else begin
          alu_a   = acc;
          alu_b   = wlo[0] ? breg : 32'd0;
          alu_fun = ALU_ADD;
        end
      end
      ST_ITER_B: begin
        if (div_op) begin
          alu_a   = sum;
          alu_b   = breg;
          alu_fun = ALU_SUB;
        end else begin
          // Unsigned sum < addend exactly when the add carried out.
          alu_a   = sum;
          alu_b   = addend;
          alu_fun = ALU_LTU;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= 32'd0;
      lo     <= 32'd0;
      div_op <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      acc    <= 32'd0;
      wlo    <= 32'd0;
      breg   <= 32'd0;
      sum    <= 32'd0;
      addend <= 32'd0;
      ge     <= 1'b0;
      count  <= 6'd0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            div_op <= op[1];
            neg_q  <= signed_in & (opa[31] ^ opb[31]);
            neg_r  <= signed_in & opa[31];
            acc    <= 32'd0;
            count  <= 6'd0;
            busy   <= 1'b1;
            state  <= ST_ITER_A;
            if (op[1]) begin
              wlo  <= abs_ops[63:32];   // dividend shifts out of wlo
              breg <= abs_ops[31:0];    // divisor
            end else begin
              wlo  <= abs_ops[31:0];    // multiplier shifts out of wlo
              breg <= abs_ops[63:32];   // multiplicand
            end
          end
        end
        ST_ITER_A: begin
          sum    <= div_op ? rs : alu_z;
          addend <= alu_b;
          // A set bit 31 before the shift means rs overflowed 32 bits and
          // is certainly >= divisor.
          ge     <= acc[31] | ~alu_z[0];
          state  <= ST_ITER_B;
        end
        ST_ITER_B: begin
          if (div_op) begin
            acc <= ge ? alu_z : sum;
            wlo <= {wlo[30:0], ge};
          end else begin
            acc <= {alu_z[0], sum[31:1]};
            wlo <= {sum[0], wlo[31:1]};
          end
          count <= count + 6'd1;
          state <= (count == LAST) ? ST_FIXUP : ST_ITER_A;
        end
        ST_FIXUP: begin
          hi <= fix_res[63:32];
          // On divide by zero the remainder equals |opa|, so the normal
          // remainder fixup already restores the raw dividend in hi.
          lo    <= (div_op && breg == 32'd0) ? 32'hFFFF_FFFF : fix_res[31:0];
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule : muldiv_seq
`default_nettype wire
